// File: rtl/s4ga_pkg.sv
// rtl/s4ga_pkg.sv - shared S4GA config-stream geometry helpers and FSM encodings
package s4ga_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RESET  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_HALT   = 2'd3;

    function automatic int s4ga_clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) r++;
        return r;
    endfunction

    // LUT inputs address constants, FPGA inputs and LUT outputs: 3 + I + N sources.
    function automatic int s4ga_idx_w(input int n, input int i);
        return s4ga_clog2(3 + i + n);
    endfunction

    function automatic int s4ga_idx_segs(input int n, input int i, input int si_w);
        return (s4ga_idx_w(n, i) + si_w - 1) / si_w;
    endfunction

    function automatic int s4ga_mask_segs(input int k, input int si_w);
        return ((1 << k) + si_w - 1) / si_w;
    endfunction

    function automatic int s4ga_ll(input int n, input int k, input int i, input int si_w);
        return k * s4ga_idx_segs(n, i, si_w) + s4ga_mask_segs(k, si_w);
    endfunction

    function automatic int s4ga_cfg_w(input int n, input int k, input int i);
        return k * s4ga_idx_w(n, i) + (1 << k);
    endfunction

endpackage

// File: rtl/s4ga_cfg_pad.sv
// rtl/s4ga_cfg_pad.sv - zero-pads a packed LUT config word into its segment-aligned frame
module s4ga_cfg_pad
    import s4ga_pkg::*;
#(
    parameter int N    = 89,
    parameter int K    = 5,
    parameter int I    = 2,
    parameter int SI_W = 4,
    localparam int CFG_W = s4ga_cfg_w(N, K, I),
    localparam int FR_W  = s4ga_ll(N, K, I, SI_W) * SI_W
) (
    input  logic [CFG_W-1:0] cfg_data_i,
    output logic [FR_W-1:0]  frame_o
);

    localparam int IDX_W    = s4ga_idx_w(N, I);
    localparam int IDX_PAD  = s4ga_idx_segs(N, I, SI_W) * SI_W;
    localparam int MASK_W   = 1 << K;
    localparam int MASK_PAD = s4ga_mask_segs(K, SI_W) * SI_W;

    // Mask sits at the LSB end, idx[0] just above it, idx[K-1] at the MSB end.
    always_comb begin
        frame_o = '0;
        frame_o[MASK_W-1:0] = cfg_data_i[MASK_W-1:0];
        for (int j = 0; j < K; j++) begin
            frame_o[MASK_PAD + j*IDX_PAD +: IDX_W] = cfg_data_i[MASK_W + j*IDX_W +: IDX_W];
        end
    end

endmodule

// File: rtl/s4ga_cfg_tx.sv
// rtl/s4ga_cfg_tx.sv - serializes LUT config words into the S4GA core's si/rst stream
module s4ga_cfg_tx
    import s4ga_pkg::*;
#(
    parameter int N          = 89,
    parameter int K          = 5,
    parameter int I          = 2,
    parameter int SI_W       = 4,
    parameter int RST_CYCLES = 2 * N,
    localparam int CFG_W = s4ga_cfg_w(N, K, I),
    localparam int N_W   = (N > 1) ? s4ga_clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CFG_W-1:0] cfg_data,
    output logic [SI_W-1:0]  si,
    output logic             tgt_rst,
    output logic [N_W-1:0]   lut_n,
    output logic             frame_done,
    output logic             underrun
);

    localparam int LL    = s4ga_ll(N, K, I, SI_W);
    localparam int FR_W  = LL * SI_W;
    localparam int SEG_W = (LL > 1) ? s4ga_clog2(LL) : 1;
    localparam int CNT_W = s4ga_clog2(RST_CYCLES + 1);

    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(LL - 1);
    localparam logic [N_W-1:0]   LUT_LAST = N_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [N_W-1:0]   lut_q, lut_d;
    logic [FR_W-1:0]  shift_q, shift_d;
    logic [CFG_W-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             tgt_rst_q, tgt_rst_d;
    logic             frame_done_q, frame_done_d;
    logic             underrun_q, underrun_d;

    logic             unload;
    logic             ready_w;
    logic             accept;
    logic             avail;
    logic             load;
    logic [CFG_W-1:0] load_word;
    logic [FR_W-1:0]  frame;

    // Boundary cycles are where the held word moves into the shifter.
    always_comb begin
        unload = ((state_q == ST_RESET)  && (cnt_q == CNT_LAST)) ||
                 ((state_q == ST_STREAM) && (seg_q == SEG_LAST));
        ready_w = en && ((state_q == ST_RESET) || (state_q == ST_STREAM)) &&
                  (!buf_full_q || unload);
        accept    = cfg_valid && ready_w;
        avail     = buf_full_q || accept;
        load_word = buf_full_q ? buf_q : cfg_data;
    end

    s4ga_cfg_pad #(
        .N    (N),
        .K    (K),
        .I    (I),
        .SI_W (SI_W)
    ) u_pad (
        .cfg_data_i (load_word),
        .frame_o    (frame)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seg_d      = seg_q;
        lut_d      = lut_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        underrun_d = underrun_q;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end
            end
            ST_RESET: begin
                if (cnt_q == CNT_LAST) begin
                    if (avail) begin
                        state_d = ST_STREAM;
                        load    = 1'b1;
                        lut_d   = '0;
                    end else begin
                        state_d    = ST_HALT;
                        underrun_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STREAM: begin
                if (seg_q == SEG_LAST) begin
                    if (avail) begin
                        load  = 1'b1;
                        lut_d = (lut_q == LUT_LAST) ? '0 : lut_q + 1'b1;
                    end else begin
                        state_d    = ST_HALT;
                        underrun_d = 1'b1;
                    end
                end else begin
                    seg_d   = seg_q + 1'b1;
                    shift_d = shift_q << SI_W;
                end
            end
            ST_HALT: begin
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            shift_d = frame;
            seg_d   = '0;
        end

        // A word arriving while the buffer is empty at a boundary bypasses the buffer.
        if (accept && !(unload && !buf_full_q)) begin
            buf_d      = cfg_data;
            buf_full_d = 1'b1;
        end else if (load && buf_full_q) begin
            buf_full_d = 1'b0;
        end

        if (!en) state_d = ST_IDLE;

        if (state_d != ST_STREAM) shift_d = '0;

        if (state_d == ST_IDLE) begin
            buf_full_d = 1'b0;
            underrun_d = 1'b0;
            seg_d      = '0;
            lut_d      = '0;
            cnt_d      = '0;
        end

        tgt_rst_d    = (state_d != ST_STREAM);
        frame_done_d = (state_d == ST_STREAM) && (seg_d == SEG_LAST) && (lut_d == LUT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            seg_q        <= '0;
            lut_q        <= '0;
            shift_q      <= '0;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            tgt_rst_q    <= 1'b1;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seg_q        <= seg_d;
            lut_q        <= lut_d;
            shift_q      <= shift_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            tgt_rst_q    <= tgt_rst_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign si         = shift_q[FR_W-1 -: SI_W];
    assign cfg_ready  = ready_w;
    assign tgt_rst    = tgt_rst_q;
    assign lut_n      = lut_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_s4ga_cfg_tx.sv
// tb/tb_s4ga_cfg_tx.sv - directed self-checking bench for s4ga_cfg_tx (N=7 K=3 I=1 SI_W=4)
module tb_s4ga_cfg_tx;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [19:0] cfg_data;
    logic [3:0]  si;
    logic        tgt_rst;
    logic [2:0]  lut_n;
    logic        frame_done;
    logic        underrun;

    int n_cmp;
    int n_err;

    logic [19:0] src_q[$];
    logic [19:0] wb [0:7];
    logic [19:0] wc [0:3];
    logic [19:0] wd [0:2];
    logic [3:0]  exp0 [0:4];

    s4ga_cfg_tx #(
        .N          (7),
        .K          (3),
        .I          (1),
        .SI_W       (4),
        .RST_CYCLES (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .si         (si),
        .tgt_rst    (tgt_rst),
        .lut_n      (lut_n),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // With IDX_W == SI_W and no mask padding, the frame is the word itself, MSB first.
    function automatic logic [3:0] seg_of(input logic [19:0] w, input int j);
        return w[19 - 4*j -: 4];
    endfunction

    task automatic present();
        if (src_q.size() > 0) begin
            cfg_valid = 1'b1;
            cfg_data  = src_q[0];
        end else begin
            cfg_valid = 1'b0;
            cfg_data  = '0;
        end
        #1;
    endtask

    task automatic cyc();
        logic hs;
        hs = cfg_valid && cfg_ready;
        @(posedge clk);
        #2;
        if (hs && src_q.size() > 0) void'(src_q.pop_front());
        present();
    endtask

    task automatic wait_stream(input string tag);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (tgt_rst === 1'b1 && n < 50);
        chk(tag, n, 11);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        wb[0] = 20'h0A53C; wb[1] = 20'h1237E; wb[2] = 20'h4560F; wb[3] = 20'h789A5;
        wb[4] = 20'hBCD81; wb[5] = 20'hEF0FF; wb[6] = 20'h32100; wb[7] = 20'h9B6C3;
        wc[0] = 20'h5A1F0; wc[1] = 20'h6B2E1; wc[2] = 20'h7C3D2; wc[3] = 20'h8D4C3;
        wd[0] = 20'h13579; wd[1] = 20'h2468A; wd[2] = 20'hFEDCB;
        exp0[0] = 4'h0; exp0[1] = 4'hA; exp0[2] = 4'h5; exp0[3] = 4'h3; exp0[4] = 4'hC;

        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        #12;
        chk("rst_si", si, 0);
        chk("rst_tgt_rst", tgt_rst, 1);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_lut_n", lut_n, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_underrun", underrun, 0);

        // Startup with prefill, then a continuous 8-word source.
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        en    = 1'b1;
        for (int k = 0; k < 8; k++) src_q.push_back(wb[k]);
        present();
        wait_stream("a_rst_len");

        for (int j = 0; j < 35; j++) begin
            chk("b_si", si, seg_of(wb[j/5], j%5));
            chk("b_lut_n", lut_n, j/5);
            chk("b_frame_done", frame_done, (j == 34));
            chk("b_tgt_rst", tgt_rst, 0);
            if (j < 5) chk("a_w0_seg", si, exp0[j]);
            cyc();
        end
        chk("b_wrap_lut_n", lut_n, 0);
        chk("b_wrap_si", si, seg_of(wb[7], 0));
        chk("b_wrap_frame_done", frame_done, 0);

        // Abandon LUT mid-way by dropping en.
        cyc();
        cyc();
        en = 1'b0;
        #1;
        cyc();
        chk("e_tgt_rst", tgt_rst, 1);
        chk("e_si", si, 0);
        chk("e_cfg_ready", cfg_ready, 0);
        chk("e_underrun", underrun, 0);
        src_q.delete();
        present();

        // Four words only: underrun at the LUT-3 boundary.
        en = 1'b1;
        for (int k = 0; k < 4; k++) src_q.push_back(wc[k]);
        present();
        wait_stream("c_rst_len");
        chk("c_si0", si, seg_of(wc[0], 0));
        for (int j = 0; j < 19; j++) cyc();
        chk("c_lut_n", lut_n, 3);
        chk("c_si_last", si, seg_of(wc[3], 4));
        chk("c_ready_empty", cfg_ready, 1);
        cyc();
        chk("c_underrun", underrun, 1);
        chk("c_tgt_rst", tgt_rst, 1);
        chk("c_si_zero", si, 0);
        chk("c_cfg_ready", cfg_ready, 0);
        chk("c_frame_done", frame_done, 0);
        cyc();
        chk("c_underrun_sticky", underrun, 1);
        en = 1'b0;
        #1;
        cyc();
        chk("c_idle_underrun", underrun, 0);
        chk("c_idle_tgt_rst", tgt_rst, 1);
        chk("c_idle_cfg_ready", cfg_ready, 0);

        // Word offered only in the boundary cycle with an empty buffer.
        en = 1'b1;
        src_q.push_back(wd[0]);
        src_q.push_back(wd[1]);
        present();
        wait_stream("d_rst_len");
        for (int j = 0; j < 9; j++) cyc();
        chk("d_lut_n1", lut_n, 1);
        chk("d_si_last", si, seg_of(wd[1], 4));
        chk("d_ready", cfg_ready, 1);
        src_q.push_back(wd[2]);
        present();
        cyc();
        chk("d_si0", si, seg_of(wd[2], 0));
        chk("d_lut_n2", lut_n, 2);
        chk("d_underrun", underrun, 0);
        chk("d_tgt_rst", tgt_rst, 0);
        cyc();
        cyc();
        chk("d_si2", si, seg_of(wd[2], 2));

        // Async reset mid-stream takes effect without a clock edge.
        rst_n = 1'b0;
        #1;
        chk("r_si", si, 0);
        chk("r_tgt_rst", tgt_rst, 1);
        chk("r_lut_n", lut_n, 0);
        chk("r_frame_done", frame_done, 0);
        chk("r_underrun", underrun, 0);
        chk("r_cfg_ready", cfg_ready, 0);
        #20;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
